// File: rtl/host_frame_loader.sv
// host_frame_loader
//   Parses host command frames arriving byte-by-byte from the UART receiver
//   and turns them into Unified Buffer writes, instruction-memory writes or
//   an execution-start pulse. The error code is sticky: each error overwrites
//   it, and each successful frame clears it.
//
//   Frame formats:
//     0x01 addr count payload[count*32]   WRITE_UB    (256-bit words)
//     0x02 addr count payload[count*4]    WRITE_INSTR (32-bit words, addr < 32)
//     0x03                                START
//   Payload bytes are little-endian within a word.
//
//   Optional feature: define HOST_FRAME_LOADER_CHECKSUM_EN to require a
//   trailing XOR checksum byte on every frame. START fires only after a
//   correct checksum.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   rx_data/rx_valid/rx_ready   byte input; rx_ready = ~exec_busy
//   exec_busy                   pauses intake and the inter-byte timeout
//   ub_wr_en/addr/data          one-cycle UB write strobe, 8-bit addr, 256-bit data
//   instr_wr_en/addr/data       one-cycle instruction write, 5-bit addr, 32-bit data
//   start_execution             one-cycle start pulse
//   busy                        frame in progress
//   err_pulse/err_code          one-cycle error pulse, sticky last error code
module host_frame_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic         exec_busy,
  output logic         ub_wr_en,
  output logic [7:0]   ub_wr_addr,
  output logic [255:0] ub_wr_data,
  output logic         instr_wr_en,
  output logic [4:0]   instr_wr_addr,
  output logic [31:0]  instr_wr_data,
  output logic         start_execution,
  output logic         busy,
  output logic         err_pulse,
  output logic [2:0]   err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_PAYLOAD
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OPCODE   = 3'd1;
  localparam logic [2:0] ERR_ZERO_CNT = 3'd2;
  localparam logic [2:0] ERR_IADDR    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
  localparam logic [2:0] ERR_CSUM     = 3'd5;
`endif

  state_t         state;
  logic           is_ub;
  logic [7:0]     addr;
  logic [7:0]     count;
  logic [4:0]     byte_idx;
  logic [255:0]   pack;
  logic [31:0]    idle_cnt;
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
  logic [7:0]     csum;
  logic           pending_start;
`endif

  logic           accept;
  logic           word_done;
  logic           timeout_hit;
  logic [255:0]   packed_word;

  assign rx_ready = ~exec_busy;
  assign accept   = rx_valid & ~exec_busy;
  assign busy     = (state != S_IDLE);

  assign word_done   = is_ub ? (byte_idx == 5'd31) : (byte_idx == 5'd3);
  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
  assign timeout_hit = (state != S_IDLE) && !rx_valid && !exec_busy &&
                       (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    packed_word = pack;
    packed_word[{byte_idx, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      is_ub           <= 1'b0;
      addr            <= '0;
      count           <= '0;
      byte_idx        <= '0;
      pack            <= '0;
      idle_cnt        <= '0;
      ub_wr_en        <= 1'b0;
      ub_wr_addr      <= '0;
      ub_wr_data      <= '0;
      instr_wr_en     <= 1'b0;
      instr_wr_addr   <= '0;
      instr_wr_data   <= '0;
      start_execution <= 1'b0;
      err_pulse       <= 1'b0;
      err_code        <= ERR_NONE;
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
      csum            <= '0;
      pending_start   <= 1'b0;
`endif
    end else begin
      ub_wr_en        <= 1'b0;
      instr_wr_en     <= 1'b0;
      start_execution <= 1'b0;
      err_pulse       <= 1'b0;

      if (state == S_IDLE || accept) begin
        idle_cnt <= '0;
      end else if (!exec_busy) begin
        idle_cnt <= idle_cnt + 32'd1;
      end

      if (timeout_hit) begin
        state     <= S_IDLE;
        pack      <= '0;
        err_pulse <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end else if (accept) begin
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
        csum <= (state == S_IDLE) ? rx_data : (csum ^ rx_data);
`endif
        case (state)
          S_IDLE: begin
            case (rx_data)
              8'h01, 8'h02: begin
                is_ub <= (rx_data == 8'h01);
                state <= S_ADDR;
              end
              8'h03: begin
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
                pending_start <= 1'b1;
                state         <= S_CSUM;
`else
                start_execution <= 1'b1;
                err_code        <= ERR_NONE;
`endif
              end
              default: begin
                err_pulse <= 1'b1;
                err_code  <= ERR_OPCODE;
              end
            endcase
          end
          S_ADDR: begin
            addr <= rx_data;
            if (!is_ub && rx_data[7:5] != 3'b000) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_IADDR;
              state     <= S_IDLE;
            end else begin
              state <= S_COUNT;
            end
          end
          S_COUNT: begin
            if (rx_data == 8'd0) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_ZERO_CNT;
              state     <= S_IDLE;
            end else begin
              count    <= rx_data;
              byte_idx <= '0;
              pack     <= '0;
              state    <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (word_done) begin
              if (is_ub) begin
                ub_wr_en   <= 1'b1;
                ub_wr_addr <= addr;
                ub_wr_data <= packed_word;
                addr       <= addr + 8'd1;
              end else begin
                instr_wr_en   <= 1'b1;
                instr_wr_addr <= addr[4:0];
                instr_wr_data <= packed_word[31:0];
                addr          <= {3'b000, addr[4:0] + 5'd1};
              end
              pack     <= '0;
              byte_idx <= '0;
              count    <= count - 8'd1;
              if (count == 8'd1) begin
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
                pending_start <= 1'b0;
                state         <= S_CSUM;
`else
                err_code <= ERR_NONE;
                state    <= S_IDLE;
`endif
              end
            end else begin
              pack     <= packed_word;
              byte_idx <= byte_idx + 5'd1;
            end
          end
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
          S_CSUM: begin
            state <= S_IDLE;
            if (rx_data == csum) begin
              err_code        <= ERR_NONE;
              start_execution <= pending_start;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= ERR_CSUM;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_host_frame_loader.sv
// Testbench for host_frame_loader: directed frames from the test plan plus a
// randomized frame mix. Expected writes, errors and start pulses are queued
// when a frame is issued; a negedge monitor pops them as the DUT strobes.
module tb_host_frame_loader;

  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         exec_busy;
  logic         ub_wr_en;
  logic [7:0]   ub_wr_addr;
  logic [255:0] ub_wr_data;
  logic         instr_wr_en;
  logic [4:0]   instr_wr_addr;
  logic [31:0]  instr_wr_data;
  logic         start_execution;
  logic         busy;
  logic         err_pulse;
  logic [2:0]   err_code;

  host_frame_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .exec_busy(exec_busy),
    .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
    .instr_wr_en(instr_wr_en), .instr_wr_addr(instr_wr_addr),
    .instr_wr_data(instr_wr_data),
    .start_execution(start_execution), .busy(busy),
    .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [255:0] data; } ub_exp_t;
  typedef struct { logic [4:0] addr; logic [31:0]  data; } instr_exp_t;

  ub_exp_t    exp_ub[$];
  instr_exp_t exp_instr[$];
  logic [2:0] exp_err[$];
  int         exp_starts = 0;
  logic [7:0] frame_q[$];
  logic [2:0] exp_code = 3'd0;

  int checks = 0;
  int errors = 0;

  ub_exp_t    mon_ub;
  instr_exp_t mon_instr;
  logic [2:0] mon_err;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: strobe seen with nothing expected", name);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (ub_wr_en) begin
        if (exp_ub.size() == 0) unexpected("ub_wr_en");
        else begin
          mon_ub = exp_ub.pop_front();
          check("ub_addr", ub_wr_addr, mon_ub.addr);
          check("ub_data", ub_wr_data, mon_ub.data);
        end
      end
      if (instr_wr_en) begin
        if (exp_instr.size() == 0) unexpected("instr_wr_en");
        else begin
          mon_instr = exp_instr.pop_front();
          check("instr_addr", instr_wr_addr, mon_instr.addr);
          check("instr_data", instr_wr_data, mon_instr.data);
        end
      end
      if (err_pulse) begin
        if (exp_err.size() == 0) unexpected("err_pulse");
        else begin
          mon_err = exp_err.pop_front();
          check("err_code_on_pulse", err_code, mon_err);
        end
      end
      if (start_execution) begin
        if (exp_starts == 0) unexpected("start_execution");
        else exp_starts--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte; random exec_busy stalls hold it until accepted.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      exec_busy = ($urandom_range(0, 5) == 0);
      tick();
    end while (exec_busy);
    rx_valid = 1'b0;
    exec_busy = 1'b0;
  endtask

  task automatic send_frame(input bit with_csum, input bit gaps);
    logic [7:0] x;
    x = 8'h00;
    foreach (frame_q[i]) begin
      x ^= frame_q[i];
      send_byte(frame_q[i]);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
    if (with_csum) send_byte(x);
`else
    if (with_csum) x = 8'h00;
`endif
    frame_q.delete();
  endtask

  // Reference model: word w goes to (addr+w) mod depth, byte k of a word at bits 8k+7:8k.
  task automatic write_frame(input bit ub, input logic [7:0] addr, input logic [7:0] cnt, input bit seq);
    int unsigned wb;
    logic [7:0] pl[$];
    logic [255:0] d;
    wb = ub ? 32 : 4;
    for (int unsigned i = 0; i < cnt * wb; i++) pl.push_back(seq ? 8'(i) : 8'($urandom));
    for (int unsigned w = 0; w < cnt; w++) begin
      d = '0;
      for (int unsigned k = 0; k < wb; k++) d[8*k +: 8] = pl[w*wb + k];
      if (ub) exp_ub.push_back('{8'((addr + w) % 256), d});
      else    exp_instr.push_back('{5'((addr + w) % 32), d[31:0]});
    end
    frame_q.push_back(ub ? 8'h01 : 8'h02);
    frame_q.push_back(addr);
    frame_q.push_back(cnt);
    foreach (pl[i]) frame_q.push_back(pl[i]);
    exp_code = 3'd0;
    send_frame(1'b1, 1'b1);
  endtask

  task automatic start_frame();
    exp_starts++;
    exp_code = 3'd0;
    frame_q.push_back(8'h03);
    send_frame(1'b1, 1'b0);
  endtask

  task automatic bad_frame(input logic [7:0] b0, input logic [7:0] b1, input int n, input logic [2:0] code);
    exp_err.push_back(code);
    exp_code = code;
    frame_q.push_back(b0);
    if (n > 1) frame_q.push_back(b1);
    send_frame(1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 64; i++) begin
      if (exp_ub.size() == 0 && exp_instr.size() == 0 && exp_err.size() == 0 && exp_starts == 0) break;
      tick();
    end
    check(name, exp_ub.size() + exp_instr.size() + exp_err.size() + exp_starts, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int r;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; exec_busy = 1'b0;
    repeat (2) tick();
    check("rst_ub_wr_en", ub_wr_en, 0);
    check("rst_ub_addr", ub_wr_addr, 0);
    check("rst_ub_data", ub_wr_data, 0);
    check("rst_instr_wr_en", instr_wr_en, 0);
    check("rst_instr_addr", instr_wr_addr, 0);
    check("rst_instr_data", instr_wr_data, 0);
    check("rst_start", start_execution, 0);
    check("rst_busy", busy, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_code", err_code, 0);
    check("rst_rx_ready", rx_ready, 1);
    exec_busy = 1'b1; #1;
    check("rx_ready_busy", rx_ready, 0);
    exec_busy = 1'b0;
    rst = 1'b0;
    tick();

    // UB write 01 05 01 00..1F
    write_frame(1'b1, 8'h05, 8'd1, 1'b1);
    drain("drain_ub");
    check("ub_err_code", err_code, 0);

    // Instruction burst wrapping 31 -> 0
    write_frame(1'b0, 8'h1F, 8'd2, 1'b1);
    drain("drain_instr_wrap");

    bad_frame(8'h7E, 8'h00, 1, 3'd1);
    drain("drain_bad_opcode");
    check("bad_opcode_code", err_code, 1);
    check("bad_opcode_busy", busy, 0);

    // 02 20 -> addr error; the following 01 opens a frame that then times out
    bad_frame(8'h02, 8'h20, 2, 3'd3);
    drain("drain_bad_iaddr");
    check("bad_iaddr_code", err_code, 3);
    bad_frame(8'h01, 8'h00, 1, 3'd4);
    drain("drain_addr_timeout");

    // 01 00 00 -> zero count
    frame_q.push_back(8'h01);
    bad_frame(8'h00, 8'h00, 2, 3'd2);
    drain("drain_zero_count");
    check("zero_count_code", err_code, 2);

    // Reset in the middle of a payload: no write, everything back to reset
    frame_q.push_back(8'h01); frame_q.push_back(8'h00); frame_q.push_back(8'h01);
    for (int i = 0; i < 5; i++) frame_q.push_back(8'(i));
    send_frame(1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_err_code", err_code, 0);
    rst = 1'b0;
    tick();

    // Timeout: 01 00 01 + 10 bytes then silence
    frame_q.push_back(8'h01); frame_q.push_back(8'h00); frame_q.push_back(8'h01);
    for (int i = 0; i < 10; i++) frame_q.push_back(8'($urandom));
    send_frame(1'b0, 1'b0);
    exp_err.push_back(3'd4);
    repeat (TMO - 1) tick();
    check("timeout_early_code", err_code, 0);
    check("timeout_early_busy", busy, 1);
    tick();
    check("timeout_code", err_code, 4);
    check("timeout_pulse", err_pulse, 1);
    check("timeout_busy", busy, 0);
    drain("drain_timeout");
    write_frame(1'b1, 8'hFF, 8'd2, 1'b0);
    drain("drain_after_timeout");
    check("timeout_cleared", err_code, 0);

    // Backpressure on a START byte
    exec_busy = 1'b1; rx_valid = 1'b1; rx_data = 8'h03;
    repeat (4) begin
      tick();
      check("bp_rx_ready", rx_ready, 0);
      check("bp_no_start", start_execution, 0);
      check("bp_busy", busy, 0);
    end
    exec_busy = 1'b0;
`ifndef HOST_FRAME_LOADER_CHECKSUM_EN
    exp_starts++;
`endif
    tick();
    rx_valid = 1'b0;
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
    exp_starts++;
    send_byte(8'h03);
`endif
    check("bp_start_pulse", start_execution, 1);
    drain("drain_start");
`ifdef HOST_FRAME_LOADER_CHECKSUM_EN
    bad_frame(8'h03, 8'h00, 2, 3'd5);
    drain("drain_bad_csum");
    check("bad_csum_code", err_code, 5);
`endif

    // Randomized frame mix
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      write_frame(1'b0, 8'($urandom_range(0, 31)), 8'($urandom_range(1, 4)), 1'b0);
      else if (r <= 6) write_frame(1'b1, 8'($urandom), 8'($urandom_range(1, 2)), 1'b0);
      else if (r == 7) start_frame();
      else if (r == 8) bad_frame(8'($urandom_range(4, 255)), 8'h00, 1, 3'd1);
      else             bad_frame(8'h02, 8'($urandom_range(32, 255)), 2, 3'd3);
      drain("drain_random");
      check("random_err_code", err_code, exp_code);
    end

    repeat (4) tick();
    drain("drain_final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/host_frame_loader.md
# host_frame_loader

Byte-stream frame decoder between the UART receiver and the TPU's Unified Buffer and instruction-memory write ports. It parses host command frames (opcode, address, count, payload) and packs payload bytes into 256-bit UB words or 32-bit instruction words. It then issues single-cycle write strobes, or a one-cycle execution-start pulse. Malformed frames, stalled frames and (optionally) checksum failures are reported through a sticky error code.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes inside a frame before abort (10 ms at 100 MHz)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid; byte accepted when rx_valid & rx_ready
- rx_ready  out  1  equals ~exec_busy
- exec_busy  in  1  controller executing; pauses intake and the timeout counter
- ub_wr_en  out  1  one-cycle UB write strobe
- ub_wr_addr  out  8  UB word address
- ub_wr_data  out  256  packed UB word
- instr_wr_en  out  1  one-cycle instruction write strobe
- instr_wr_addr  out  5  instruction address
- instr_wr_data  out  32  packed instruction
- start_execution  out  1  one-cycle start pulse
- busy  out  1  high when state != IDLE
- err_pulse  out  1  one-cycle pulse on any error
- err_code  out  3  sticky last error: 0 none, 1 bad opcode, 2 zero count, 3 instr addr out of range, 4 timeout, 5 checksum

## Operation
- States: IDLE, ADDR, COUNT, PAYLOAD, CSUM (CSUM exists only with the macro). All outputs are registered.
- IDLE, accepted byte:
  - 0x01 (WRITE_UB) or 0x02 (WRITE_INSTR): go to ADDR.
  - 0x03 (START): pulse start_execution; stay in IDLE, or go to CSUM with the macro.
  - Any other value: err 1, stay in IDLE.
- ADDR: latch the address byte, then go to COUNT.
  - For WRITE_INSTR, addr[7:5] != 0 gives err 3 and a return to IDLE.
- COUNT: count = number of words.
  - 0 gives err 2 and a return to IDLE.
  - Otherwise clear the byte index and go to PAYLOAD.
- PAYLOAD: bytes are little-endian, so byte k of a word goes to bits [8k+7:8k].
  - Words are 32 bytes (UB) or 4 bytes (instr).
  - After the last byte of a word: strobe the write with the current address, increment the address, decrement the word count.
  - UB address wraps 255 to 0. Instr address wraps 31 to 0.
  - After the last word: return to IDLE, or go to CSUM with the macro.
- The packing register is zeroed at the start of each word, so no stale bytes carry over.
- Successful frame completion clears err_code to 0. Errors overwrite err_code.
- Timeout: in any state other than IDLE, an idle counter increments each cycle with no accepted byte while exec_busy=0.
  - The counter resets on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: err 4, return to IDLE, discard any partial word.
  - Words already written are not retracted.
- rst mid-frame: everything returns to reset state in the next cycle. No write strobe is issued for a partial word.

## Timing
- Reset values: every output 0 (including err_code=0 and busy=0), except rx_ready=~exec_busy.
- Write strobe asserts in the cycle after the final byte of a word is accepted. Address and data are stable in that same cycle.
- start_execution asserts in the cycle after the 0x03 byte is accepted; with the macro, the cycle after a correct checksum byte is accepted.
- err_pulse and the err_code update occur in the cycle after the offending byte, or after the counter reaches TIMEOUT_CYCLES.
- Sustained throughput is one byte per cycle. Back-to-back frames need no gap.
- If exec_busy and rx_valid are high in the same cycle, the byte is not accepted.

## Configuration
- HOST_FRAME_LOADER_CHECKSUM_EN defined:
  - Every frame ends with one checksum byte equal to the XOR of all preceding frame bytes, opcode included.
  - A mismatch gives err 5. Payload writes already issued stand.
  - START fires only after a correct checksum.
- Macro undefined: no CSUM state, and frames end after the last payload byte or the 0x03 byte.

## Test plan
- UB write: 01 05 01 followed by bytes 00..1F -> one ub_wr_en, addr 0x05, data[7:0]=0x00, data[255:248]=0x1F; err_code 0.
- Instruction burst wrap: 02 1F 02, then 8 bytes -> instr writes at addr 31 then 0, data 0x03020100 then 0x07060504.
- Bad input:
  - Opcode 0x7E -> err_pulse, err_code 1.
  - 02 20 01 -> err_code 3, no write.
  - 01 00 00 -> err_code 2.
- Timeout with TIMEOUT_CYCLES=16: 01 00 01 plus 10 bytes, then silence -> err_code 4 at the 16th idle cycle, no ub_wr_en; the next valid frame clears err_code.
- Start and backpressure: exec_busy=1 with byte 03 presented -> rx_ready 0, nothing accepted. Release exec_busy -> start_execution pulses once (macro on: only after checksum byte 03; a wrong checksum byte gives err_code 5).
